// File: rtl/scl_spare_alloc_ctrl.sv
// ============================================================================
// Module   : scl_spare_alloc_ctrl
// Purpose  : Round-robin allocator handing out spare-cell slots to requesters,
//            with an optional tie-low self-test that marks faulty slots.
// Options  : define SCL_SPARE_SELFTEST_EN to compile in the self-test FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scl_spare_alloc_ctrl #(
    parameter  int NREQ  = 4,
    parameter  int NSLOT = 8,
    localparam int SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rel,
    output logic [NREQ-1:0]  gnt,
    output logic [SW-1:0]    gnt_slot,
    output logic [NSLOT-1:0] slot_busy,
    output logic             full,
    input  logic [NSLOT-1:0] spare_lo,
    input  logic             chk_start,
    output logic             chk_busy,
    output logic             chk_done,
    output logic [NSLOT-1:0] fail_map
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Allocation state
    logic [NREQ-1:0]          gnt_q,       gnt_d;
    logic [SW-1:0]            gnt_slot_q,  gnt_slot_d;
    logic [NSLOT-1:0]         slot_busy_q, slot_busy_d;
    logic [NREQ-1:0]          own_vld_q,   own_vld_d;
    logic [NREQ-1:0][SW-1:0]  own_slot_q,  own_slot_d;
    logic [RW-1:0]            rr_q,        rr_d;

    // Self-test view seen by the allocator
    logic [NSLOT-1:0]         fail_map_w;
    logic                     chk_busy_w;
    logic                     chk_done_w;

    // Arbitration helpers
    logic [NSLOT-1:0]         avail_w;
    logic                     free_found_w;
    logic [SW-1:0]            free_idx_w;
    logic [NREQ-1:0]          elig_w;
    logic                     win_found_w;
    logic [RW-1:0]            win_idx_w;
    logic [RW:0]              cand_w;
    logic                     grant_go_w;

    // A holder never competes; a holder's req is simply ignored
    assign elig_w  = req & ~own_vld_q;
    assign avail_w = ~(slot_busy_q | fail_map_w);
    assign full    = ~|avail_w;

    // Lowest-index slot that is neither allocated nor marked faulty
    always_comb begin
        free_found_w = 1'b0;
        free_idx_w   = '0;
        for (int s = NSLOT - 1; s >= 0; s--) begin
            if (avail_w[s]) begin
                free_found_w = 1'b1;
                free_idx_w   = SW'(s);
            end
        end
    end

    // Round-robin search from rr; descending loop so the nearest candidate wins
    always_comb begin
        win_found_w = 1'b0;
        win_idx_w   = '0;
        cand_w      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_w = {1'b0, rr_q} + (RW+1)'(k);
            if (cand_w >= (RW+1)'(NREQ)) begin
                cand_w = cand_w - (RW+1)'(NREQ);
            end
            if (elig_w[cand_w[RW-1:0]]) begin
                win_found_w = 1'b1;
                win_idx_w   = cand_w[RW-1:0];
            end
        end
    end

    // No grant while the slot pool is exhausted or a scan owns the bitmap
    assign grant_go_w = win_found_w & free_found_w & ~chk_busy_w;

    // Next-state: releases free slots now, grants claim a slot already free
    always_comb begin
        gnt_d       = '0;
        gnt_slot_d  = '0;
        slot_busy_d = slot_busy_q;
        own_vld_d   = own_vld_q;
        own_slot_d  = own_slot_q;
        rr_d        = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (rel[i] && own_vld_q[i]) begin
                own_vld_d[i]                = 1'b0;
                slot_busy_d[own_slot_q[i]]  = 1'b0;
            end
        end
        if (grant_go_w) begin
            gnt_d[win_idx_w]      = 1'b1;
            gnt_slot_d            = free_idx_w;
            slot_busy_d[free_idx_w] = 1'b1;
            own_vld_d[win_idx_w]  = 1'b1;
            own_slot_d[win_idx_w] = free_idx_w;
            rr_d = (win_idx_w == RW'(NREQ - 1)) ? '0 : win_idx_w + 1'b1;
        end
    end

    // Allocation registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gnt_q       <= '0;
            gnt_slot_q  <= '0;
            slot_busy_q <= '0;
            own_vld_q   <= '0;
            own_slot_q  <= '0;
            rr_q        <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_slot_q  <= gnt_slot_d;
            slot_busy_q <= slot_busy_d;
            own_vld_q   <= own_vld_d;
            own_slot_q  <= own_slot_d;
            rr_q        <= rr_d;
        end
    end

`ifdef SCL_SPARE_SELFTEST_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } st_e;

    st_e              st_q;
    logic [SW-1:0]    idx_q;
    logic [NSLOT-1:0] fail_map_q;
    logic             chk_busy_q;
    logic             chk_done_q;

    // Self-test walk: one slot per cycle, only free slots are sampled
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            st_q       <= ST_IDLE;
            idx_q      <= '0;
            fail_map_q <= '0;
            chk_busy_q <= 1'b0;
            chk_done_q <= 1'b0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (chk_start) begin
                        st_q       <= ST_SCAN;
                        idx_q      <= '0;
                        chk_busy_q <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!slot_busy_q[idx_q] && spare_lo[idx_q]) begin
                        fail_map_q[idx_q] <= 1'b1;
                    end
                    if (idx_q == SW'(NSLOT - 1)) begin
                        st_q       <= ST_DONE;
                        chk_busy_q <= 1'b0;
                        chk_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    st_q       <= ST_IDLE;
                    chk_done_q <= 1'b0;
                end
                default: begin
                    st_q       <= ST_IDLE;
                    chk_busy_q <= 1'b0;
                    chk_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign fail_map_w = fail_map_q;
    assign chk_busy_w = chk_busy_q;
    assign chk_done_w = chk_done_q;
`else
    // Self-test absent: inputs are intentionally sunk, outputs are constant
    logic w_unused_selftest;
    assign w_unused_selftest = ^{spare_lo, chk_start};
    assign fail_map_w = '0;
    assign chk_busy_w = 1'b0;
    assign chk_done_w = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_slot  = gnt_slot_q;
    assign slot_busy = slot_busy_q;
    assign fail_map  = fail_map_w;
    assign chk_busy  = chk_busy_w;
    assign chk_done  = chk_done_w;

endmodule

`default_nettype wire

// File: tb/tb_scl_spare_alloc_ctrl.sv
// ============================================================================
// Module   : tb_scl_spare_alloc_ctrl
// Purpose  : Scoreboard bench for scl_spare_alloc_ctrl; a behavioural model
//            predicts grants and per-cycle status, a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scl_spare_alloc_ctrl;

    localparam int NREQ  = 9;
    localparam int NSLOT = 8;
    localparam int SW    = 3;

`ifdef SCL_SPARE_SELFTEST_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetb = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  rel = '0;
    logic [NSLOT-1:0] spare_lo = '0;
    logic             chk_start = 1'b0;
    logic [NREQ-1:0]  gnt;
    logic [SW-1:0]    gnt_slot;
    logic [NSLOT-1:0] slot_busy;
    logic             full;
    logic             chk_busy;
    logic             chk_done;
    logic [NSLOT-1:0] fail_map;

    scl_spare_alloc_ctrl #(.NREQ(NREQ), .NSLOT(NSLOT)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_slot  (gnt_slot),
        .slot_busy (slot_busy),
        .full      (full),
        .spare_lo  (spare_lo),
        .chk_start (chk_start),
        .chk_busy  (chk_busy),
        .chk_done  (chk_done),
        .fail_map  (fail_map)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int stamp; int who; int slot; } gexp_t;
    typedef struct {
        int stamp;
        logic [NSLOT-1:0] busy;
        logic [NSLOT-1:0] fail;
        logic full;
        logic cb;
        logic cd;
    } sexp_t;

    gexp_t gq[$];
    sexp_t sq[$];

    // Reference model: who holds which slot, which slots are taken or faulty
    int holder[NREQ];
    bit mbusy[NSLOT];
    bit mfail[NSLOT];
    int mrr;
    int mscan;   // -1 idle, 0..NSLOT-1 slot under test, NSLOT completion cycle

    function automatic void model_reset();
        for (int i = 0; i < NREQ; i++) holder[i] = -1;
        for (int s = 0; s < NSLOT; s++) begin
            mbusy[s] = 1'b0;
            mfail[s] = 1'b0;
        end
        mrr   = 0;
        mscan = -1;
    endfunction

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                              input logic cs, input logic [NSLOT-1:0] sl);
        int    win;
        int    slot;
        bit    scanning;
        bit    all_taken;
        gexp_t g;
        sexp_t s;
        win      = -1;
        slot     = -1;
        scanning = (mscan >= 0) && (mscan < NSLOT);
        for (int k = 0; k < NSLOT; k++) begin
            if (!mbusy[k] && !mfail[k]) begin
                slot = k;
                break;
            end
        end
        if (!scanning && slot >= 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (mrr + k) % NREQ;
                if (r[i] && holder[i] < 0) begin
                    win = i;
                    break;
                end
            end
        end
        if (scanning && !mbusy[mscan] && sl[mscan]) mfail[mscan] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (l[i] && holder[i] >= 0) begin
                mbusy[holder[i]] = 1'b0;
                holder[i] = -1;
            end
        end
        if (win >= 0) begin
            mbusy[slot] = 1'b1;
            holder[win] = slot;
            mrr = (win + 1) % NREQ;
            g.stamp = cyc + 1;
            g.who   = win;
            g.slot  = slot;
            gq.push_back(g);
        end
        if (ST_EN) begin
            if (mscan < 0) begin
                if (cs) mscan = 0;
            end else if (mscan == NSLOT) begin
                mscan = -1;
            end else begin
                mscan = mscan + 1;
            end
        end
        all_taken = 1'b1;
        for (int k = 0; k < NSLOT; k++) begin
            s.busy[k] = mbusy[k];
            s.fail[k] = mfail[k];
            if (!mbusy[k] && !mfail[k]) all_taken = 1'b0;
        end
        s.stamp = cyc + 1;
        s.full  = all_taken;
        s.cb    = (mscan >= 0) && (mscan < NSLOT);
        s.cd    = (mscan == NSLOT);
        sq.push_back(s);
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                         input logic cs, input logic [NSLOT-1:0] sl);
        @(negedge clk);
        req       = r;
        rel       = l;
        chk_start = cs;
        spare_lo  = sl;
        model_step(r, l, cs, sl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req       = '0;
        rel       = '0;
        chk_start = 1'b0;
        spare_lo  = '0;
        #2 resetb = 1'b0;
        #1;
        check("rst_gnt",       64'(gnt),       64'd0);
        check("rst_gnt_slot",  64'(gnt_slot),  64'd0);
        check("rst_slot_busy", 64'(slot_busy), 64'd0);
        check("rst_full",      64'(full),      64'd0);
        check("rst_chk_busy",  64'(chk_busy),  64'd0);
        check("rst_chk_done",  64'(chk_done),  64'd0);
        check("rst_fail_map",  64'(fail_map),  64'd0);
        gq.delete();
        sq.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
    endtask

    // Monitor: compare grants and status against queued expectations
    initial begin : monitor
        gexp_t g;
        sexp_t s;
        logic [NREQ-1:0] eg;
        logic [SW-1:0]   es;
        forever begin
            @(posedge clk);
            #1;
            if (resetb && mon_en) begin
                eg = '0;
                es = '0;
                if (gq.size() > 0 && gq[0].stamp == cyc) begin
                    g = gq.pop_front();
                    eg[g.who] = 1'b1;
                    es = SW'(g.slot);
                end
                if (gnt != '0 || eg != '0) begin
                    check("gnt",      64'(gnt),      64'(eg));
                    check("gnt_slot", 64'(gnt_slot), 64'(es));
                end else begin
                    check("gnt_slot_idle", 64'(gnt_slot), 64'd0);
                end
                if (sq.size() > 0 && sq[0].stamp == cyc) begin
                    s = sq.pop_front();
                    check("slot_busy", 64'(slot_busy), 64'(s.busy));
                    check("fail_map",  64'(fail_map),  64'(s.fail));
                    check("full",      64'(full),      64'(s.full));
                    check("chk_busy",  64'(chk_busy),  64'(s.cb));
                    check("chk_done",  64'(chk_done),  64'(s.cd));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin : stim
        model_reset();
        do_reset();
        mon_en = 1'b1;

        // Single request from reset
        drive(9'h001, '0, 1'b0, '0);
        drive('0, '0, 1'b0, '0);
        drive('0, 9'h001, 1'b0, '0);
        drive('0, '0, 1'b0, '0);

        // Four simultaneous requesters from reset, served in order
        do_reset();
        repeat (4) drive(9'h00F, '0, 1'b0, '0);
        drive('0, '0, 1'b0, '0);
        drive(9'h001, 9'h00F, 1'b0, '0);
        drive(9'h001, '0, 1'b0, '0);
        drive('0, '0, 1'b0, '0);

        // Fill every slot, then same-cycle rel[0] / req[1], then free another
        do_reset();
        repeat (8) drive(9'h1FD, '0, 1'b0, '0);
        drive('0, '0, 1'b0, '0);
        drive(9'h1FF, '0, 1'b0, '0);
        drive(9'h002, 9'h001, 1'b0, '0);
        drive(9'h002, '0, 1'b0, '0);
        drive(9'h001, '0, 1'b0, '0);
        drive(9'h001, 9'h020, 1'b0, '0);
        drive(9'h001, '0, 1'b0, '0);
        drive('0, '0, 1'b0, '0);
        drive('0, '1, 1'b0, '0);
        drive('0, '0, 1'b0, '0);

`ifdef SCL_SPARE_SELFTEST_EN
        // Self-test on idle slots marks slot 2; requests during scan wait
        do_reset();
        drive('0, '0, 1'b1, 8'h04);
        drive(9'h001, '0, 1'b1, 8'h04);
        repeat (9) drive(9'h001, '0, 1'b0, 8'h04);
        repeat (3) drive(9'h00F, '0, 1'b0, '0);
        drive('0, '0, 1'b0, '0);
        // Reset in the middle of a scan
        drive('0, '0, 1'b1, 8'hFF);
        repeat (4) drive('0, '0, 1'b0, 8'hFF);
        do_reset();
        drive('0, '0, 1'b0, '0);
`endif

        // Randomized traffic with periodic asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ-1:0]  r;
            logic [NREQ-1:0]  l;
            logic             cs;
            logic [NSLOT-1:0] sl;
            r  = NREQ'($urandom);
            l  = NREQ'($urandom & $urandom & $urandom);
            cs = ($urandom_range(0, 99) == 0);
            sl = NSLOT'($urandom & $urandom & $urandom & $urandom);
            drive(r, l, cs, sl);
            if (n % 600 == 599) do_reset();
        end

        repeat (3) drive('0, '0, 1'b0, '0);
        @(negedge clk);
        check("grant_queue_drained",  64'(gq.size()), 64'd0);
        check("status_queue_drained", 64'(sq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scl_spare_alloc_ctrl.md
SCL_SPARE_ALLOC_CTRL -- requirements
Module: scl_spare_alloc_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter NSLOT, default 8: number of spare-cell slots; SW = clog2(NSLOT).
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port resetb, input, 1: reset, asynchronous, active-low.
REQ-005 Port req, input, NREQ: per-requester level request for one slot.
REQ-006 Port rel, input, NREQ: per-requester one-cycle release of the slot it holds.
REQ-007 Port gnt, output, NREQ: one-hot one-cycle grant pulse.
REQ-008 Port gnt_slot, output, SW: granted slot index, valid only while gnt is nonzero, else 0.
REQ-009 Port slot_busy, output, NSLOT: allocation bitmap.
REQ-010 Port full, output, 1: high when no slot is both free and non-failed.
REQ-011 Port spare_lo, input, NSLOT: tie-low outputs (LO) of the spare-cell instances.
REQ-012 Port chk_start, input, 1: one-cycle self-test start.
REQ-013 Ports chk_busy, chk_done, output, 1 each: self-test running / one-cycle completion pulse.
REQ-014 Port fail_map, output, NSLOT: sticky per-slot self-test failure.

Function
REQ-015 Requester i is eligible when req[i]=1 and it holds no slot; req from a holder is ignored.
REQ-016 At most one grant per cycle, round-robin among eligible requesters: search starts at pointer rr (reset 0), rr becomes winner+1 mod NREQ after a grant, unchanged otherwise.
REQ-017 Granted slot is the lowest index with slot_busy=0 and fail_map=0.
REQ-018 Grant latency 1 cycle: request sampled in cycle N -> gnt/gnt_slot registered, visible in cycle N+1; slot_busy bit and owner record set in the same cycle N+1.
REQ-019 Requester drops req the cycle after gnt; a req still high then is ignored because the requester is a holder.
REQ-020 rel[i] from a holder clears its slot_busy bit in the next cycle; rel from a non-holder has no effect.
REQ-021 Slot released in cycle N is not grantable before cycle N+1 (no same-cycle reuse); simultaneous rel and grant by different requesters both take effect.
REQ-022 rel and req from the same requester in the same cycle: release only; requester is eligible from the next cycle.
REQ-023 When full=1, no grant issues and rr does not advance; full is combinational from slot_busy|fail_map.
REQ-024 Owner table: one SW-bit slot index plus valid bit per requester.

Reset
REQ-025 On resetb=0 asynchronously: gnt=0, gnt_slot=0, slot_busy=0, owner valid=0, rr=0, fail_map=0, chk_busy=0, chk_done=0, test FSM in IDLE.
REQ-026 Reset mid-self-test or mid-allocation discards all state; no partial fail_map survives.

Configuration
REQ-027 Macro SCL_SPARE_SELFTEST_EN defined: self-test FSM IDLE->SCAN->DONE->IDLE compiled in.
REQ-028 IDLE: chk_start=1 -> SCAN, idx=0, chk_busy=1; chk_start in SCAN/DONE ignored.
REQ-029 SCAN: one slot per cycle; for a free slot, spare_lo[idx]=1 sets fail_map[idx]; busy slots are skipped (not sampled); after idx=NSLOT-1 -> DONE.
REQ-030 DONE: chk_busy=0, chk_done=1 for exactly one cycle, then IDLE; fail_map sticky until reset.
REQ-031 While chk_busy=1 no grant issues (rel still honoured); scan of NSLOT=8 takes 8 cycles, busy from cycle after chk_start.
REQ-032 Macro undefined: no FSM; spare_lo and chk_start ignored; chk_busy=0, chk_done=0, fail_map=0 constantly.

Verification
REQ-033 Reset, req=4'b0001 one cycle -> next cycle gnt=4'b0001, gnt_slot=0, slot_busy=8'h01.
REQ-034 req=4'b1111 held 4 cycles from reset -> grants in order 0,1,2,3 on slots 0,1,2,3, slot_busy=8'h0F, rr=0.
REQ-035 All 8 slots held by repeated alloc/release pattern, full=1; new req -> no gnt; rel[k] -> next cycle full=0, following cycle grant takes freed slot.
REQ-036 (SELFTEST_EN) slots idle, spare_lo=8'h04, chk_start pulse -> chk_busy 8 cycles, chk_done pulse, fail_map=8'h04; subsequent grants skip slot 2.
REQ-037 (SELFTEST_EN) resetb low during SCAN at idx=3 -> immediately chk_busy=0, fail_map=0, FSM IDLE.
REQ-038 Same-cycle rel[0] (holding slot 0) and req[1] with slots 1..7 busy -> no grant that cycle, slot 0 granted to requester 1 one cycle later.
